// File: rtl/mcu_isa_pkg.sv
// ISA definitions for the 8-bit MCU fetch/decode stage: opcodes, ALU codes, IR fields,
// decoded-control payload and FSM state encoding.
package mcu_isa_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned REG_AW  = 3;
  localparam int unsigned IMM_W   = 6;
  localparam int unsigned FS_W    = 4;

  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned DR_MSB  = 11;
  localparam int unsigned DR_LSB  = 9;
  localparam int unsigned SA_MSB  = 8;
  localparam int unsigned SA_LSB  = 6;
  localparam int unsigned SB_MSB  = 2;
  localparam int unsigned SB_LSB  = 0;
  localparam int unsigned IMM_MSB = 5;
  localparam int unsigned IMM_LSB = 0;

  typedef logic [OP_W-1:0] opcode_t;

  localparam opcode_t OP_NOP  = 4'h0;
  localparam opcode_t OP_ADD  = 4'h1;
  localparam opcode_t OP_SUB  = 4'h2;
  localparam opcode_t OP_AND  = 4'h3;
  localparam opcode_t OP_OR   = 4'h4;
  localparam opcode_t OP_XOR  = 4'h5;
  localparam opcode_t OP_ADDI = 4'h6;
  localparam opcode_t OP_ANDI = 4'h7;
  localparam opcode_t OP_ORI  = 4'h8;
  localparam opcode_t OP_LD   = 4'h9;
  localparam opcode_t OP_ST   = 4'hA;
  localparam opcode_t OP_LDI  = 4'hB;
  localparam opcode_t OP_BRZ  = 4'hC;
  localparam opcode_t OP_JMP  = 4'hD;
  localparam opcode_t OP_RSVD = 4'hE;
  localparam opcode_t OP_HALT = 4'hF;

  // Code 0 is left unused so "no ALU operation" is distinguishable from ADD.
  localparam logic [FS_W-1:0] FS_ADD   = 4'h1;
  localparam logic [FS_W-1:0] FS_SUB   = 4'h2;
  localparam logic [FS_W-1:0] FS_AND   = 4'h3;
  localparam logic [FS_W-1:0] FS_OR    = 4'h4;
  localparam logic [FS_W-1:0] FS_XOR   = 4'h5;
  localparam logic [FS_W-1:0] FS_PASSB = 4'h6;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DECODE  = 2'd1,
    ST_EXEC    = 2'd2,
    ST_HALTED  = 2'd3
  } state_t;

  typedef struct packed {
    logic [REG_AW-1:0] da;
    logic [REG_AW-1:0] aa;
    logic [REG_AW-1:0] ba;
    logic [IMM_W-1:0]  imm;
    logic              cs;
    logic              mb;
    logic [FS_W-1:0]   fs;
    logic              md;
    logic              wr_en;
    logic              mem_wr;
    logic              is_brz;
    logic              is_jmp;
    logic              is_halt;
  } dec_ctrl_t;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational IR decoder producing datapath controls.
module instr_decoder
  import mcu_isa_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  output dec_ctrl_t          ctrl
);

  opcode_t op;

  always_comb begin
    ctrl     = '0;
    op       = ir[OP_MSB:OP_LSB];
    ctrl.da  = ir[DR_MSB:DR_LSB];
    ctrl.aa  = ir[SA_MSB:SA_LSB];
    ctrl.ba  = ir[SB_MSB:SB_LSB];
    ctrl.imm = ir[IMM_MSB:IMM_LSB];
    case (op)
      OP_ADD:  begin ctrl.fs = FS_ADD; ctrl.wr_en = 1'b1; end
      OP_SUB:  begin ctrl.fs = FS_SUB; ctrl.wr_en = 1'b1; end
      OP_AND:  begin ctrl.fs = FS_AND; ctrl.wr_en = 1'b1; end
      OP_OR:   begin ctrl.fs = FS_OR;  ctrl.wr_en = 1'b1; end
      OP_XOR:  begin ctrl.fs = FS_XOR; ctrl.wr_en = 1'b1; end
      OP_ADDI: begin ctrl.fs = FS_ADD; ctrl.mb = 1'b1; ctrl.cs = 1'b1; ctrl.wr_en = 1'b1; end
      OP_ANDI: begin ctrl.fs = FS_AND; ctrl.mb = 1'b1; ctrl.wr_en = 1'b1; end
      OP_ORI:  begin ctrl.fs = FS_OR;  ctrl.mb = 1'b1; ctrl.wr_en = 1'b1; end
      OP_LD:   begin ctrl.md = 1'b1; ctrl.wr_en = 1'b1; end
      OP_ST:   ctrl.mem_wr = 1'b1;
      OP_LDI:  begin ctrl.fs = FS_PASSB; ctrl.mb = 1'b1; ctrl.cs = 1'b1; ctrl.wr_en = 1'b1; end
      OP_BRZ:  ctrl.is_brz = 1'b1;
      OP_JMP:  ctrl.is_jmp = 1'b1;
      OP_HALT: ctrl.is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// Fetch/decode control stage: PC, IR, FETCH/DECODE/EXEC FSM and strobe gating.
// Optional feature macro IFD_HALT_EN: opcode F halts the core until reset.
module instr_fetch_decode
  import mcu_isa_pkg::*;
#(
  parameter int unsigned PC_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PC_W-1:0]     imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                zero_flag,
  output logic [REG_AW-1:0]   da,
  output logic [REG_AW-1:0]   aa,
  output logic [REG_AW-1:0]   ba,
  output logic [IMM_W-1:0]    imm_value,
  output logic                cs,
  output logic                mb,
  output logic [FS_W-1:0]     fs,
  output logic                md,
  output logic                rw,
  output logic                mw,
  output logic                instr_done,
  output logic                halted
);

  state_t               state, state_nxt;
  logic [PC_W-1:0]      pc, pc_nxt;
  logic [INSTR_W-1:0]   ir, ir_nxt;
  logic [PC_W-1:0]      offset;
  logic                 br_taken;
  dec_ctrl_t            dec;

  instr_decoder u_dec (
    .ir   (ir),
    .ctrl (dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
    end
  end

  // Next state, PC/IR update and strobes; everything forced low while rst is high.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    ir_nxt     = ir;
    imem_req   = 1'b0;
    rw         = 1'b0;
    mw         = 1'b0;
    instr_done = 1'b0;
    halted     = 1'b0;
    offset     = PC_W'($signed(dec.imm));
    br_taken   = dec.is_jmp | (dec.is_brz & zero_flag);
    case (state)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_nxt    = imem_rdata;
          state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: state_nxt = ST_EXEC;
      ST_EXEC: begin
        rw         = dec.wr_en;
        mw         = dec.mem_wr;
        instr_done = 1'b1;
        pc_nxt     = br_taken ? pc + PC_W'(1) + offset : pc + PC_W'(1);
`ifdef IFD_HALT_EN
        state_nxt  = dec.is_halt ? ST_HALTED : ST_FETCH;
`else
        state_nxt  = ST_FETCH;
`endif
      end
      ST_HALTED: begin
`ifdef IFD_HALT_EN
        halted    = 1'b1;
`else
        state_nxt = ST_FETCH;
`endif
      end
      default: state_nxt = ST_FETCH;
    endcase
    if (rst) begin
      imem_req   = 1'b0;
      rw         = 1'b0;
      mw         = 1'b0;
      instr_done = 1'b0;
      halted     = 1'b0;
    end
  end

`ifndef IFD_HALT_EN
  logic unused_halt;
  assign unused_halt = dec.is_halt;
`endif

  assign imem_addr = rst ? '0 : pc;
  assign da        = rst ? '0 : dec.da;
  assign aa        = rst ? '0 : dec.aa;
  assign ba        = rst ? '0 : dec.ba;
  assign imm_value = rst ? '0 : dec.imm;
  assign cs        = rst ? 1'b0 : dec.cs;
  assign mb        = rst ? 1'b0 : dec.mb;
  assign fs        = rst ? '0 : dec.fs;
  assign md        = rst ? 1'b0 : dec.md;

endmodule
